// File: rtl/rvfi_pkg.sv
// Shared RVFI commit record type, halt-instruction encodings and per-record helpers
// used by the commit packer and its lane compactor.
package rvfi_pkg;

  localparam int ORDER_W = 64;

  localparam logic [31:0] HALT_INST_BEQ = 32'h0000_0063;
  localparam logic [31:0] HALT_INST_JAL = 32'h0000_006F;
  localparam logic [31:0] HALT_INST_CSR = 32'hF000_2013;

  typedef struct packed {
    logic [31:0] inst;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_rdata;
    logic [31:0] rs2_rdata;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
  } rvfi_rec_t;

  // A self-loop (pc unchanged) or one of the known spin encodings marks the end of a program.
  function automatic logic is_halt(input rvfi_rec_t r);
    return (r.pc_rdata == r.pc_wdata) ||
           (r.inst == HALT_INST_BEQ) ||
           (r.inst == HALT_INST_JAL) ||
           (r.inst == HALT_INST_CSR);
  endfunction

  function automatic rvfi_rec_t sanitize(input rvfi_rec_t r);
    rvfi_rec_t s;
    s = r;
    if (r.rs1_addr == 5'd0) s.rs1_rdata = '0;
    if (r.rs2_addr == 5'd0) s.rs2_rdata = '0;
    if (r.rd_addr == 5'd0)  s.rd_wdata  = '0;
    s.mem_addr[1:0] = 2'b00;
    return s;
  endfunction

endpackage

// File: rtl/rvfi_lane_compactor.sv
// Combinational compaction of a sparse lane mask onto channels 0..k-1, preserving lane order.
module rvfi_lane_compactor
  import rvfi_pkg::*;
#(
  parameter  int CHANNELS = 8,
  localparam int CNT_W    = $clog2(CHANNELS + 1)
) (
  input  logic      [CHANNELS-1:0] i_valid,
  input  rvfi_rec_t [CHANNELS-1:0] i_rec,
  input  logic      [CHANNELS-1:0] i_halt,
  output logic      [CHANNELS-1:0] o_valid,
  output rvfi_rec_t [CHANNELS-1:0] o_rec,
  output logic      [CHANNELS-1:0] o_halt,
  output logic      [CNT_W-1:0]    o_count
);

  logic [CNT_W-1:0] w_pos [CHANNELS];

  // Each lane's destination channel is the number of valid lanes below it.
  always_comb begin
    logic [CNT_W-1:0] w_run;
    w_run = '0;
    for (int j = 0; j < CHANNELS; j++) begin
      w_pos[j] = w_run;
      w_run    = w_run + CNT_W'(i_valid[j]);
    end
    o_count = w_run;
  end

  always_comb begin
    o_valid = '0;
    o_rec   = '0;
    o_halt  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      for (int j = 0; j < CHANNELS; j++) begin
        if (i_valid[j] && (w_pos[j] == CNT_W'(i))) begin
          o_valid[i] = 1'b1;
          o_rec[i]   = i_rec[j];
          o_halt[i]  = i_halt[j];
        end
      end
    end
  end

endmodule

// File: rtl/rvfi_commit_packer.sv
// Packs sparse ROB retire lanes into dense RVFI channels with commit ordering,
// halt detection (RUN -> HALTED) and a no-commit watchdog.
module rvfi_commit_packer
  import rvfi_pkg::*;
#(
  parameter int CHANNELS    = 8,
  parameter int WDOG_CYCLES = 10000
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic      [CHANNELS-1:0]            ret_valid,
  input  rvfi_rec_t [CHANNELS-1:0]            ret_rec,
  output logic      [CHANNELS-1:0]            rvfi_valid,
  output logic      [CHANNELS-1:0][ORDER_W-1:0] rvfi_order,
  output rvfi_rec_t [CHANNELS-1:0]            rvfi_rec,
  output logic      [CHANNELS-1:0]            rvfi_halt,
  output logic                                halted,
  output logic                                wdog_err
);

  localparam int CNT_W  = $clog2(CHANNELS + 1);
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
  localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(WDOG_CYCLES);

  typedef enum logic {ST_RUN, ST_HALTED} state_t;

  state_t                             r_state;
  logic      [CHANNELS-1:0]           r_valid;
  logic      [CHANNELS-1:0][ORDER_W-1:0] r_order;
  rvfi_rec_t [CHANNELS-1:0]           r_rec;
  logic      [CHANNELS-1:0]           r_halt;
  logic                               r_wdog_err;
  logic      [ORDER_W-1:0]            r_order_cnt;
  logic      [WDOG_W-1:0]             r_wdog_cnt;

  rvfi_rec_t [CHANNELS-1:0] w_san;
  logic      [CHANNELS-1:0] w_lane_halt;
  logic      [CHANNELS-1:0] w_first_halt;
  logic      [CHANNELS-1:0] w_keep;
  logic      [CHANNELS-1:0] w_accept;
  logic      [CHANNELS-1:0] w_ch_valid;
  rvfi_rec_t [CHANNELS-1:0] w_ch_rec;
  logic      [CHANNELS-1:0] w_ch_halt;
  logic      [CNT_W-1:0]    w_count;
  logic                     w_commit_halt;

  always_comb begin
    for (int j = 0; j < CHANNELS; j++) begin
      w_san[j]       = sanitize(ret_rec[j]);
      w_lane_halt[j] = ret_valid[j] && is_halt(ret_rec[j]);
    end
  end

  // Keep lanes up to and including the lowest-lane halt; everything above it is dropped.
  assign w_first_halt  = w_lane_halt & (~w_lane_halt + CHANNELS'(1));
  assign w_keep        = (w_first_halt == '0) ? '1 : (w_first_halt | (w_first_halt - CHANNELS'(1)));
  assign w_accept      = (r_state == ST_RUN) ? (ret_valid & w_keep) : '0;
  assign w_commit_halt = |(w_first_halt & w_accept);

  rvfi_lane_compactor #(.CHANNELS(CHANNELS)) u_compactor (
    .i_valid (w_accept),
    .i_rec   (w_san),
    .i_halt  (w_first_halt),
    .o_valid (w_ch_valid),
    .o_rec   (w_ch_rec),
    .o_halt  (w_ch_halt),
    .o_count (w_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_RUN;
      r_valid     <= '0;
      r_order     <= '0;
      r_rec       <= '0;
      r_halt      <= '0;
      r_wdog_err  <= 1'b0;
      r_order_cnt <= '0;
      r_wdog_cnt  <= '0;
    end else begin
      r_valid     <= w_ch_valid;
      r_rec       <= w_ch_rec;
      r_halt      <= w_ch_halt;
      r_order_cnt <= r_order_cnt + ORDER_W'(w_count);
      for (int i = 0; i < CHANNELS; i++) begin
        r_order[i] <= w_ch_valid[i] ? (r_order_cnt + ORDER_W'(i)) : '0;
      end
      case (r_state)
        ST_RUN: begin
          // The watchdog error is meaningless once the program has halted, so it is dropped there.
          if (w_commit_halt) begin
            r_state    <= ST_HALTED;
            r_wdog_err <= 1'b0;
            r_wdog_cnt <= '0;
          end else if (w_count != '0) begin
            r_wdog_cnt <= '0;
          end else if (r_wdog_cnt != WDOG_MAX) begin
            r_wdog_cnt <= r_wdog_cnt + WDOG_W'(1);
            if ((r_wdog_cnt + WDOG_W'(1)) == WDOG_MAX) r_wdog_err <= 1'b1;
          end
        end
        default: r_state <= ST_HALTED;
      endcase
    end
  end

  assign rvfi_valid = r_valid;
  assign rvfi_order = r_order;
  assign rvfi_rec   = r_rec;
  assign rvfi_halt  = r_halt;
  assign halted     = (r_state == ST_HALTED);
  assign wdog_err   = r_wdog_err;

  a_ret_valid_known: assert property (@(posedge clk) disable iff (!rst_n) !$isunknown(ret_valid));

endmodule

// File: tb/tb_rvfi_commit_packer.sv
// Self-checking bench for rvfi_commit_packer: table-driven bundles against a scoreboard
// model, plus hand-written halt, watchdog and mid-stream reset sequences.
module tb_rvfi_commit_packer;
  import rvfi_pkg::*;

  localparam int CH   = 8;
  localparam int WDOG = 16;

  logic                        clk = 1'b0;
  logic                        rst_n;
  logic      [CH-1:0]          retValid;
  rvfi_rec_t [CH-1:0]          laneRec;
  logic      [CH-1:0]          rvfiValid;
  logic      [CH-1:0][63:0]    rvfiOrder;
  rvfi_rec_t [CH-1:0]          rvfiRec;
  logic      [CH-1:0]          rvfiHalt;
  logic                        halted;
  logic                        wdogErr;

  rvfi_commit_packer #(.CHANNELS(CH), .WDOG_CYCLES(WDOG)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ret_valid  (retValid),
    .ret_rec    (laneRec),
    .rvfi_valid (rvfiValid),
    .rvfi_order (rvfiOrder),
    .rvfi_rec   (rvfiRec),
    .rvfi_halt  (rvfiHalt),
    .halted     (halted),
    .wdog_err   (wdogErr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CH-1:0]          valid;
    logic [CH-1:0]          halt;
    logic [CH-1:0][63:0]    order;
    rvfi_rec_t [CH-1:0]     rec;
    logic                   halted;
  } exp_t;

  typedef struct {
    logic [7:0]  valid;
    int          seed;
    logic [7:0]  expValid;
    logic [63:0] expFirstOrder;
  } vec_t;

  exp_t        expQ[$];
  int          checks = 0;
  int          passes = 0;
  logic [63:0] mOrder;
  logic        mHalted;

  function automatic logic modelHalt(input rvfi_rec_t r);
    if (r.pc_rdata == r.pc_wdata) return 1'b1;
    case (r.inst)
      32'h0000_0063, 32'h0000_006F, 32'hF000_2013: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic rvfi_rec_t modelClean(input rvfi_rec_t r);
    rvfi_rec_t c;
    c = r;
    c.rs1_rdata = (r.rs1_addr != 5'd0) ? r.rs1_rdata : 32'd0;
    c.rs2_rdata = (r.rs2_addr != 5'd0) ? r.rs2_rdata : 32'd0;
    c.rd_wdata  = (r.rd_addr  != 5'd0) ? r.rd_wdata  : 32'd0;
    c.mem_addr  = r.mem_addr & 32'hFFFF_FFFC;
    return c;
  endfunction

  task automatic checkValue(input string name, input logic [511:0] act, input logic [511:0] req);
    checks++;
    if (act === req) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  task automatic fillLanes(input int seed);
    for (int l = 0; l < CH; l++) begin
      laneRec[l]           = '0;
      laneRec[l].inst      = 32'h0000_0013 | (32'(l) << 7) | (32'(seed) << 15);
      laneRec[l].rs1_addr  = 5'((l + seed) % 4);
      laneRec[l].rs2_addr  = 5'((l * 5 + seed) % 32);
      laneRec[l].rd_addr   = 5'((l * 3 + seed) % 8);
      laneRec[l].rs1_rdata = $urandom;
      laneRec[l].rs2_rdata = $urandom;
      laneRec[l].rd_wdata  = $urandom;
      laneRec[l].pc_rdata  = 32'h1000 + 32'(l * 4) + 32'(seed * 64);
      laneRec[l].pc_wdata  = laneRec[l].pc_rdata + 32'd4;
      laneRec[l].mem_addr  = $urandom;
      laneRec[l].mem_rmask = 4'($urandom);
      laneRec[l].mem_wmask = 4'($urandom);
      laneRec[l].mem_rdata = $urandom;
      laneRec[l].mem_wdata = $urandom;
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (expQ.size() == 0) begin
      checkValue("scoreboard_empty", 512'd1, 512'd0);
      return;
    end
    e = expQ.pop_front();
    checkValue("rvfi_valid", rvfiValid, e.valid);
    checkValue("rvfi_halt", rvfiHalt, e.halt);
    checkValue("halted", halted, e.halted);
    for (int c = 0; c < CH; c++) begin
      checkValue($sformatf("order_ch%0d", c), rvfiOrder[c], e.order[c]);
      checkValue($sformatf("rec_ch%0d", c), rvfiRec[c], e.rec[c]);
    end
  endtask

  // Drives one bundle at a negedge, predicts the packed result, then samples at the next negedge.
  task automatic applyStimulus(input logic [7:0] v);
    exp_t e;
    int   k;
    e = '0;
    k = 0;
    if (!mHalted) begin
      for (int l = 0; l < CH; l++) begin
        if (v[l]) begin
          e.valid[k] = 1'b1;
          e.order[k] = mOrder + 64'(k);
          e.rec[k]   = modelClean(laneRec[l]);
          if (modelHalt(laneRec[l])) begin
            e.halt[k] = 1'b1;
            mHalted   = 1'b1;
            k++;
            break;
          end
          k++;
        end
      end
    end
    mOrder   = mOrder + 64'(k);
    e.halted = mHalted;
    expQ.push_back(e);
    retValid = v;
    @(posedge clk);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic applyReset();
    rst_n    = 1'b0;
    retValid = '0;
    @(posedge clk);
    @(negedge clk);
    checkValue("reset_valid", rvfiValid, 8'h00);
    checkValue("reset_halt", rvfiHalt, 8'h00);
    checkValue("reset_halted", halted, 1'b0);
    checkValue("reset_wdog", wdogErr, 1'b0);
    checkValue("reset_order", rvfiOrder, 512'd0);
    rst_n = 1'b1;
    expQ.delete();
    mOrder  = '0;
    mHalted = 1'b0;
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{8'b0000_0111, 1, 8'h07, 64'd0};
    vecs[1] = '{8'b1111_1111, 2, 8'hFF, 64'd3};
    vecs[2] = '{8'b0000_0001, 3, 8'h01, 64'd11};
    vecs[3] = '{8'b1000_0000, 4, 8'h01, 64'd12};
    vecs[4] = '{8'b0000_0000, 5, 8'h00, 64'd0};
    vecs[5] = '{8'b0101_1010, 6, 8'h0F, 64'd13};
    vecs[6] = '{8'b0001_0001, 7, 8'h03, 64'd17};
    vecs[7] = '{8'b0011_1100, 8, 8'h0F, 64'd19};

    rst_n    = 1'b0;
    retValid = '0;
    laneRec  = '0;
    mOrder   = '0;
    mHalted  = 1'b0;
    @(negedge clk);
    applyReset();

    // Sparse mask from reset: lanes 0,2,5,7 onto channels 0..3
    fillLanes(11);
    applyStimulus(8'b1010_0101);
    checkValue("sparse_valid", rvfiValid, 8'h0F);
    checkValue("sparse_ch1_inst", rvfiRec[1].inst, laneRec[2].inst);
    checkValue("sparse_ch3_inst", rvfiRec[3].inst, laneRec[7].inst);
    checkValue("sparse_ch3_order", rvfiOrder[3], 64'd3);

    applyReset();
    for (int i = 0; i < 8; i++) begin
      fillLanes(vecs[i].seed);
      applyStimulus(vecs[i].valid);
      checkValue($sformatf("vec%0d_valid", i), rvfiValid, vecs[i].expValid);
      if (vecs[i].expValid[0]) checkValue($sformatf("vec%0d_order0", i), rvfiOrder[0], vecs[i].expFirstOrder);
    end

    // x0 destination and unaligned memory address get sanitised
    fillLanes(9);
    laneRec[0].rd_addr  = 5'd0;
    laneRec[0].rd_wdata = 32'hDEAD_BEEF;
    laneRec[0].mem_addr = 32'h0000_1003;
    applyStimulus(8'h01);
    checkValue("x0_rd_wdata", rvfiRec[0].rd_wdata, 32'd0);
    checkValue("mem_addr_align", rvfiRec[0].mem_addr, 32'h0000_1000);

    // Watchdog fires after exactly WDOG idle cycles and is sticky
    applyReset();
    for (int c = 1; c <= WDOG; c++) begin
      applyStimulus(8'h00);
      if (c == WDOG - 1) checkValue("wdog_before", wdogErr, 1'b0);
      if (c == WDOG)     checkValue("wdog_fire", wdogErr, 1'b1);
    end
    fillLanes(12);
    applyStimulus(8'h01);
    checkValue("wdog_sticky_commit", wdogErr, 1'b1);
    applyStimulus(8'h00);
    checkValue("wdog_sticky_idle", wdogErr, 1'b1);

    // Lowest-lane halt wins; later lanes dropped; HALTED ignores further retires
    applyReset();
    fillLanes(13);
    laneRec[3].inst = 32'h0000_006F;
    laneRec[5].inst = 32'hF000_2013;
    applyStimulus(8'hFF);
    checkValue("halt_valid", rvfiValid, 8'h0F);
    checkValue("halt_flag", rvfiHalt, 8'h08);
    checkValue("halted_set", halted, 1'b1);
    for (int c = 0; c < 3; c++) begin
      fillLanes(14 + c);
      applyStimulus(8'hFF);
      checkValue("halted_no_output", rvfiValid, 8'h00);
    end

    // Self-loop (pc unchanged) is also a halt
    applyReset();
    fillLanes(20);
    laneRec[2].pc_wdata = laneRec[2].pc_rdata;
    applyStimulus(8'b0000_1110);
    checkValue("selfloop_valid", rvfiValid, 8'h03);
    checkValue("selfloop_halt", rvfiHalt, 8'h02);

    // Reset mid-stream at order 57 clears immediately and restarts ordering at 0
    applyReset();
    for (int b = 0; b < 7; b++) begin
      fillLanes(21 + b);
      applyStimulus(8'hFF);
    end
    fillLanes(30);
    applyStimulus(8'h01);
    fillLanes(31);
    applyStimulus(8'hFF);
    checkValue("order57", rvfiOrder[0], 64'd57);
    retValid = 8'hFF;
    #2 rst_n = 1'b0;
    #1;
    checkValue("async_clear_valid", rvfiValid, 8'h00);
    checkValue("async_clear_order", rvfiOrder[0], 64'd0);
    @(posedge clk);
    @(negedge clk);
    retValid = '0;
    rst_n    = 1'b1;
    expQ.delete();
    mOrder  = '0;
    mHalted = 1'b0;
    fillLanes(32);
    applyStimulus(8'h07);
    checkValue("restart_order0", rvfiOrder[0], 64'd0);
    checkValue("restart_order2", rvfiOrder[2], 64'd2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/rvfi_commit_packer.md
RVFI_COMMIT_PACKER -- requirements
Module: rvfi_commit_packer

Interface
REQ-001 SHALL have parameter CHANNELS, default 8, meaning the number of retire lanes in and RVFI channels out.
REQ-002 SHALL have parameter WDOG_CYCLES, default 10000, meaning the number of commit-free cycles before the watchdog error fires.
REQ-003 SHALL have port clk, input, 1, the single clock.
REQ-004 SHALL have port rst_n, input, 1, the reset: asynchronous and active-low.
REQ-005 SHALL have port ret_valid, input, CHANNELS, the per-lane retire strobe from the ROB; the mask may be sparse.
REQ-006 SHALL have port ret_rec, input, CHANNELS x rvfi_rec_t, the per-lane retire record.
REQ-007 SHALL have port rvfi_valid, output, CHANNELS, the packed commit strobes.
REQ-008 SHALL have port rvfi_order, output, CHANNELS x 64, the commit sequence number per channel.
REQ-009 SHALL have port rvfi_rec, output, CHANNELS x rvfi_rec_t, the sanitised record per channel.
REQ-010 SHALL have port rvfi_halt, output, CHANNELS, asserted on the channel carrying the halting instruction.
REQ-011 SHALL have port halted, output, 1, a sticky flag set once a halt has been committed.
REQ-012 SHALL have port wdog_err, output, 1, a sticky flag meaning no commit occurred within WDOG_CYCLES.

rvfi_rec_t fields: inst 32, rs1_addr 5, rs2_addr 5, rs1_rdata 32, rs2_rdata 32, rd_addr 5, rd_wdata 32, pc_rdata 32, pc_wdata 32, mem_addr 32, mem_rmask 4, mem_wmask 4, mem_rdata 32, mem_wdata 32.

Function
REQ-013 SHALL compact valid lanes to channels 0..k-1 in ascending lane order, where k = popcount(ret_valid).
REQ-014 SHALL drive the outputs from registers, with exactly one cycle of latency from ret_valid to rvfi_valid.
REQ-015 SHALL keep a 64-bit order counter, reset to 0, and give channel i the value order_cnt + i.
REQ-016 SHALL advance order_cnt by the number of records emitted that cycle; the counter wraps modulo 2^64.
REQ-017 SHALL zero rs1_rdata when rs1_addr == 0, zero rs2_rdata when rs2_addr == 0, and zero rd_wdata when rd_addr == 0.
REQ-018 SHALL drive mem_addr as {mem_addr[31:2], 2'b00}.
REQ-019 SHALL treat a record as a halt when pc_rdata == pc_wdata, or inst is 0x00000063, 0x0000006F or 0xF0002013.
REQ-020 SHALL implement two states, RUN -> HALTED, taken on the first committed halt; HALTED is left only by reset.
REQ-021 In RUN, when one cycle holds several halts, SHALL treat only the lowest-lane halt as the halt.
REQ-022 SHALL emit the halting record with rvfi_halt set, and SHALL drop every later lane in the same cycle (they consume no order).
REQ-023 In HALTED, SHALL ignore ret_valid, hold rvfi_valid at 0, and freeze order_cnt.
REQ-024 SHALL drive unused channels with rvfi_valid = 0 and all other fields = 0.
REQ-025 SHALL run a watchdog counter that clears on any emitted commit and increments otherwise while in RUN.
REQ-026 SHALL set wdog_err when the watchdog count reaches WDOG_CYCLES, and SHALL saturate the count there.
REQ-027 SHALL never assert wdog_err while in HALTED.
REQ-028 Where a ret_valid lane is X, SHALL report it by simulation assertion only; this does not change the RTL function.

Reset
REQ-029 On rst_n low, asynchronously, SHALL clear rvfi_valid, rvfi_halt, halted, wdog_err, order_cnt, the watchdog count and all records to 0, and return the state to RUN.
REQ-030 SHALL discard any bundle retiring in the same cycle that reset asserts.
REQ-031 After release, the first accepted bundle SHALL start at order 0.

Structure
REQ-032 SHALL place rvfi_rec_t, the halt-instruction constants (0x00000063, 0x0000006F, 0xF0002013) and the ORDER_W = 64 constant in the shared package rvfi_pkg.
REQ-033 SHALL put the lane compaction (prefix-popcount, then mux) in the combinational sub-module rvfi_lane_compactor.
REQ-034 SHALL keep the state machine, counters and output registers in rvfi_commit_packer.

Verification
REQ-035 Stimulus ret_valid = 8'b1010_0101 on cycle 1 -> next cycle rvfi_valid = 8'h0F, channels 0..3 carry lanes 0, 2, 5, 7, and orders are 0..3.
REQ-036 Stimulus: a first bundle of 3, then a bundle of 8 -> orders 0..2, then 3..10; order_cnt = 11.
REQ-037 Stimulus: lanes 0..7 all valid with lane 3 inst = 0x0000006F -> channels 0..3 emitted, rvfi_halt[3] = 1, halted = 1; all later ret_valid give no output.
REQ-038 Stimulus: rd_addr = 0 with rd_wdata = 0xDEADBEEF, and mem_addr = 0x1003 -> rd_wdata = 0 and mem_addr = 0x1000.
REQ-039 Stimulus: WDOG_CYCLES = 16 with no retires for 16 cycles -> wdog_err rises and stays; a later retire leaves it at 1.
REQ-040 Stimulus: rst_n pulsed low mid-stream while order = 57 -> outputs clear immediately, and the next bundle starts at order 0.
